// File: rtl/preproc_pkg.sv
// Shared types and constants for the sample preprocessing front end.
package preproc_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    LO,
    HI,
    CHK,
    DISCARD
  } parser_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/commit_fifo.sv
// Sample FIFO with a tentative write pointer: entries become visible only after commit,
// and rollback discards everything written since the last commit.
module commit_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 17,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic             rollback,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [PW-1:0]    count,
  output logic [PW-1:0]    free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    commit_ptr;
  logic [PW-1:0]    wr_ptr;

  // Storage is reset so the show-ahead output reads zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      commit_ptr <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
      if (rollback) wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr_ptr;
      if (pop && (count != '0)) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count   = commit_ptr - rd_ptr;
  assign free    = PW'(DEPTH) - (wr_ptr - rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CHK byte frames into 16-bit samples; only frames with a
// matching checksum are committed to the output FIFO.
module uart_frame_parser
  import preproc_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 64,
  parameter int         MAX_LEN      = 32,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 50000,
  localparam int        CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic [15:0]   sample_out,
  output logic          sample_last,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          frame_ok,
  output logic          err_checksum,
  output logic          err_length,
  output logic          err_overflow,
  output logic          err_timeout,
  output logic [CW-1:0] fifo_count
);

  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int CMPW = (CW > 8) ? CW : 8;

  parser_state_t state;
  logic [7:0]    chk;
  logic [7:0]    cnt;
  logic [8:0]    remaining;
  logic [7:0]    lo;
  logic [TW-1:0] idle_cnt;

  logic          timeout_hit;
  logic          wr_en;
  logic          commit;
  logic          rollback;
  logic [CW-1:0] free;

  assign timeout_hit = (state != HUNT) && (idle_cnt == TW'(TIMEOUT_CLKS));
  assign wr_en       = !timeout_hit && in_valid && (state == HI);
  assign commit      = !timeout_hit && in_valid && (state == CHK) && (in_byte == chk);
  assign rollback    = timeout_hit || (in_valid && (state == CHK) && (in_byte != chk));

  commit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (17)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  ({(cnt == 8'd1), in_byte, lo}),
    .commit   (commit),
    .rollback (rollback),
    .pop      (sample_valid && sample_ready),
    .rd_data  ({sample_last, sample_out}),
    .count    (fifo_count),
    .free     (free)
  );

  assign sample_valid = (fifo_count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HUNT;
      chk          <= '0;
      cnt          <= '0;
      remaining    <= '0;
      lo           <= '0;
      idle_cnt     <= '0;
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      if (in_valid || state == HUNT) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        err_timeout <= 1'b1;
        state       <= HUNT;
      end else if (in_valid) begin
        case (state)
          HUNT: if (in_byte == SYNC_BYTE) state <= LEN;
          LEN: begin
            chk <= in_byte;
            if (in_byte == 8'd0 || in_byte > 8'(MAX_LEN)) begin
              err_length <= 1'b1;
              state      <= HUNT;
            end else if (CMPW'(in_byte) > CMPW'(free)) begin
              // Whole frame is skipped blind so a SYNC_BYTE in its payload cannot resync.
              err_overflow <= 1'b1;
              remaining    <= {in_byte, 1'b1};
              state        <= DISCARD;
            end else begin
              cnt   <= in_byte;
              state <= LO;
            end
          end
          LO: begin
            lo    <= in_byte;
            chk   <= chk ^ in_byte;
            state <= HI;
          end
          HI: begin
            chk   <= chk ^ in_byte;
            cnt   <= cnt - 1'b1;
            state <= (cnt == 8'd1) ? CHK : LO;
          end
          CHK: begin
            if (in_byte == chk) frame_ok <= 1'b1;
            else err_checksum <= 1'b1;
            state <= HUNT;
          end
          DISCARD: begin
            remaining <= remaining - 1'b1;
            if (remaining == 9'd1) state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized frame stimulus checked against a frame-level scoreboard of committed samples and status events.
module tb_uart_frame_parser;

  localparam int FIFO_DEPTH = 64;
  localparam int MAX_LEN    = 32;
  localparam int TMO        = 300;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  localparam logic [4:0] EV_OK  = 5'b10000;
  localparam logic [4:0] EV_CHK = 5'b01000;
  localparam logic [4:0] EV_LEN = 5'b00100;
  localparam logic [4:0] EV_OVF = 5'b00010;
  localparam logic [4:0] EV_TMO = 5'b00001;

  typedef logic [15:0] sq_t[$];

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_valid = 1'b0;
  logic [15:0]   sample_out;
  logic          sample_last;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          frame_ok, err_checksum, err_length, err_overflow, err_timeout;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;
  logic [16:0] exp_q[$];
  logic [4:0]  exp_ev[$];

  uart_frame_parser #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .sample_out   (sample_out),
    .sample_last  (sample_last),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_ok     (frame_ok),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every status pulse and every popped sample is matched against the model queues.
  always @(negedge clk) begin
    if (reset_n) begin
      logic [4:0] ev;
      ev = {frame_ok, err_checksum, err_length, err_overflow, err_timeout};
      if (ev != '0) begin
        if (exp_ev.size() == 0) check_eq("event_unexpected", 32'(ev), 32'h0);
        else check_eq("event", 32'(ev), 32'(exp_ev.pop_front()));
      end
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) check_eq("sample_unexpected", {15'd0, sample_last, sample_out}, 32'h0);
        else check_eq("sample", {15'd0, sample_last, sample_out}, 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: sample_ready = 1'b0;
      1: sample_ready = 1'b1;
      default: sample_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    in_byte  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic sq_t rand_data(input int n);
    sq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    return q;
  endfunction

  task automatic send_frame(input sq_t data, input int len, input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = 8'(len);
    send_byte(8'hA5);
    if (len == 0 || len > MAX_LEN) begin
      exp_ev.push_back(EV_LEN);
      send_byte(8'(len));
      return;
    end
    if (exp_q.size() + len > FIFO_DEPTH) begin
      exp_ev.push_back(EV_OVF);
      send_byte(8'(len));
      send_byte(8'hA5);
      send_byte(8'h01);
      for (int i = 0; i < 2 * len - 1; i++) send_byte(8'($urandom));
      return;
    end
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(data[i][7:0]);
      send_byte(data[i][15:8]);
      chk ^= data[i][7:0] ^ data[i][15:8];
    end
    if (chk_flip == 8'h00) begin
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), data[i]});
      exp_ev.push_back(EV_OK);
    end else begin
      exp_ev.push_back(EV_CHK);
    end
    send_byte(chk ^ chk_flip);
  endtask

  task automatic wait_events(input string tag, input int budget);
    int n = 0;
    while (exp_ev.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_ev.size() != 0) check_eq({tag, "_event_missing"}, 32'(exp_ev.size()), 32'h0);
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_drain_left"}, 32'(exp_q.size()), 32'h0);
    tick();
    check_eq({tag, "_count_after_drain"}, 32'(fifo_count), 32'h0);
  endtask

  initial begin
    sq_t d;
    int  r;
    repeat (3) tick();
    check_eq("reset_valid", 32'(sample_valid), 32'h0);
    check_eq("reset_sample", {15'd0, sample_last, sample_out}, 32'h0);
    check_eq("reset_count", 32'(fifo_count), 32'h0);
    reset_n = 1'b1;
    tick();

    // good frame, ready high
    ready_mode = 1;
    d = '{16'h1234, 16'hABCD};
    send_frame(d, 2, 8'h00);
    wait_events("t1", 20);
    wait_drain("t1", 50);

    // bad checksum never surfaces
    send_frame(d, 2, 8'h01);
    wait_events("t2", 20);
    check_eq("t2_valid", 32'(sample_valid), 32'h0);
    check_eq("t2_count", 32'(fifo_count), 32'h0);
    send_frame(rand_data(3), 3, 8'h00);
    wait_events("t2b", 20);
    wait_drain("t2b", 50);

    // length errors
    send_frame(d, 0, 8'h00);
    wait_events("t3a", 20);
    send_frame(d, MAX_LEN + 1, 8'h00);
    wait_events("t3b", 20);
    send_frame(rand_data(4), 4, 8'h00);
    wait_events("t3c", 20);
    wait_drain("t3c", 50);

    // fill to capacity, then overflow
    ready_mode = 0;
    tick();
    send_frame(rand_data(MAX_LEN), MAX_LEN, 8'h00);
    send_frame(rand_data(MAX_LEN), MAX_LEN, 8'h00);
    wait_events("t4_fill", 20);
    check_eq("t4_full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    send_frame(rand_data(1), 1, 8'h00);
    wait_events("t4_ovf", 20);
    check_eq("t4_count_kept", 32'(fifo_count), 32'(FIFO_DEPTH));
    ready_mode = 1;
    wait_drain("t4", 200);
    send_frame(rand_data(2), 2, 8'h00);
    wait_events("t4_after", 20);
    wait_drain("t4_after", 50);

    // idle timeout after the low byte of sample 1
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    exp_ev.push_back(EV_TMO);
    wait_events("t5a", TMO + 30);
    check_eq("t5a_count", 32'(fifo_count), 32'h0);
    // timeout after one sample was already written: it must be rolled back
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hCD);
    exp_ev.push_back(EV_TMO);
    wait_events("t5b", TMO + 30);
    send_frame(rand_data(2), 2, 8'h00);
    wait_events("t5c", 20);
    wait_drain("t5c", 50);

    // reset mid-payload with committed samples held
    ready_mode = 0;
    tick();
    send_frame(rand_data(5), 5, 8'h00);
    wait_events("t6_fill", 20);
    check_eq("t6_count_before", 32'(fifo_count), 32'h5);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_n = 1'b0;
    #2;
    check_eq("t6_rst_valid", 32'(sample_valid), 32'h0);
    check_eq("t6_rst_sample", {15'd0, sample_last, sample_out}, 32'h0);
    check_eq("t6_rst_count", 32'(fifo_count), 32'h0);
    check_eq("t6_rst_pulses",
             {27'd0, frame_ok, err_checksum, err_length, err_overflow, err_timeout}, 32'h0);
    exp_q.delete();
    exp_ev.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    ready_mode = 1;
    tick();
    send_frame(rand_data(3), 3, 8'h00);
    wait_events("t6", 20);
    wait_drain("t6", 50);

    // random mix with random backpressure and junk between frames
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j);
      end
      r = $urandom_range(0, 9);
      if (r == 0) send_frame(d, ($urandom_range(0, 1) == 0) ? 0 : MAX_LEN + 1 + $urandom_range(0, 100), 8'h00);
      else if (r == 1) send_frame(rand_data(4), $urandom_range(1, 4), 8'($urandom_range(1, 255)));
      else begin
        int n;
        n = $urandom_range(1, 6);
        send_frame(rand_data(n), n, 8'h00);
      end
      wait_events("rand", 20);
    end
    ready_mode = 1;
    wait_drain("rand", 200);

    check_eq("end_events_left", 32'(exp_ev.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
